multi_alu_pipe: RTL and testbench
=================================

MULTI_ALU_PIPE -- requirements
Module: multi_alu_pipe

Interface
REQ-001 The block SHALL have parameter W, default 8: operand/result width per channel (>=4).
REQ-002 The block SHALL have parameter CH, default 3: number of independent ALU channels (>=1).
REQ-003 The block SHALL have parameter OPW, default 4: opcode width per channel (>=3).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the input bundle is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts the input bundle this cycle.
REQ-008 The block SHALL have port a, input, CH*W bits: operand A; channel k occupies bits [k*W +: W].
REQ-009 The block SHALL have port b, input, CH*W bits: operand B, packed as a.
REQ-010 The block SHALL have port op, input, CH*OPW bits: per-channel opcode, packed as a.
REQ-011 The block SHALL have port sat_en, input, 1 bit: ADD/SUB saturate when 1; sampled with the bundle.
REQ-012 The block SHALL have port out_valid, output, 1 bit: the result bundle is valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-014 The block SHALL have port r, output, CH*W bits: per-channel result, packed as a.
REQ-015 The block SHALL have port flags, output, CH*2 bits: per channel {carry/borrow, zero}; channel k occupies bits [2k +: 2].
REQ-016 The block SHALL have port err, output, 1 bit: sticky flag; set once any channel accepts an illegal opcode.
REQ-017 The block SHALL have port clr_err, input, 1 bit: synchronous clear of err.
REQ-018 The block SHALL have port txn_cnt, output, 16 bits: count of completed output handshakes.

Function
REQ-019 Opcodes SHALL be: 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 SHL a by b[$clog2(W)-1:0], 6 SHR (logical), 7 unsigned MAX.
REQ-020 Opcodes >= 8 SHALL give result 0 with both flags 0, and SHALL set err.
REQ-021 Arithmetic SHALL be unsigned, computed at W+1 bits; carry = bit W for ADD, borrow = (a<b) for SUB; carry = 0 for all other ops.
REQ-022 With sat_en=1, ADD with carry SHALL give all-ones and SUB with borrow SHALL give 0; the carry flag SHALL still report the true carry/borrow.
REQ-023 The zero flag SHALL be 1 when the final (post-saturation) W-bit result equals 0.
REQ-024 The pipeline SHALL have 2 register stages: S1 registers operands, opcodes and sat_en; S2 registers results and flags.
REQ-025 Latency SHALL be 2 cycles: a bundle accepted at edge N SHALL appear on out_valid/r after edge N+2 when out_ready=1.
REQ-026 An input handshake SHALL occur when in_valid and in_ready are both 1; an output handshake when out_valid and out_ready are both 1.
REQ-027 Each stage SHALL load when it is empty or its content moves on in the same cycle; in_ready = !S1_full | S1 advancing.
REQ-028 in_ready SHALL NOT depend combinationally on in_valid.
REQ-029 Under sustained out_ready=1 and in_valid=1, throughput SHALL be 1 bundle per cycle.
REQ-030 With out_ready=0, r, flags and out_valid SHALL hold stable; after both stages fill, in_ready SHALL drop to 0.
REQ-031 Bundles SHALL never be dropped, duplicated or reordered.
REQ-032 txn_cnt SHALL increment by 1 on each output handshake and wrap from 0xFFFF to 0.
REQ-033 If err is set and cleared in the same cycle, set SHALL win; err SHALL be set at the S1 -> S2 transfer of an illegal opcode.

Reset
REQ-034 While rst_n=0, the block SHALL asynchronously force both stages empty, out_valid=0, r=0, flags=0, err=0 and txn_cnt=0.
REQ-035 While rst_n=0, in_ready SHALL be 0; it SHALL be 1 on the first cycle after rst_n rises.
REQ-036 Reset asserted mid-operation SHALL discard in-flight bundles, and no output handshake SHALL occur for them.

Verification
REQ-037 The bench SHALL cover, with CH=3, W=8, out_ready=1: ch0 ADD 1+3, ch1 SUB 7-1, ch2 XOR 0x0F^0x1F -> after 2 cycles r = {0x10, 0x06, 0x04}, flags all 0.
REQ-038 The bench SHALL cover ADD 0xFF+0x02: sat_en=0 -> r=0x01, carry=1; sat_en=1 -> r=0xFF, carry=1.
REQ-039 The bench SHALL cover SUB 0x02-0x05 with sat_en=1 -> r=0x00, borrow=1, zero=1.
REQ-040 The bench SHALL cover backpressure: 4 back-to-back bundles, with out_ready=0 for 5 cycles -> in_ready=0 after 2 accepts; on release all 4 emerge in order, r stable while stalled.
REQ-041 The bench SHALL cover illegal opcode 9 on ch1 -> ch1 r=0, err=1 and sticky; clr_err -> err=0 on the next cycle.
REQ-042 The bench SHALL cover reset with 2 bundles in flight -> out_valid=0 and txn_cnt=0 immediately; 65537 handshakes after reset -> txn_cnt=1.

Source files
------------

// File: rtl/multi_alu_pipe.sv
// multi_alu_pipe: CH independent ALU channels behind a two-stage valid/ready pipeline.
// Stage 1 holds the operand bundle and stage 2 the results; each stage stalls on its own.
module multi_alu_pipe #(
  parameter int W   = 8,
  parameter int CH  = 3,
  parameter int OPW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH*W-1:0]   a,
  input  logic [CH*W-1:0]   b,
  input  logic [CH*OPW-1:0] op,
  input  logic              sat_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH*W-1:0]   r,
  output logic [CH*2-1:0]   flags,
  output logic              err,
  input  logic              clr_err,
  output logic [15:0]       txn_cnt
);
  localparam int SW = $clog2(W);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MAX = 3'd7
  } op_e;

  typedef struct packed {
    logic         ill;
    logic         carry;
    logic [W-1:0] res;
  } alu_res_t;

  function automatic alu_res_t alu_ch(input logic [W-1:0]   x,
                                      input logic [W-1:0]   y,
                                      input logic [OPW-1:0] o,
                                      input logic           sat);
    alu_res_t rs;
    logic [W:0] wide;
    // NOTE: every output gets a default up front so no path through the case leaves a value unassigned (no latches).
    rs   = '0;
    wide = '0;
    if (32'(o) > 32'd7) begin
      rs.ill = 1'b1;
    end else begin
      case (op_e'(o[2:0]))
        OP_ADD: begin
          wide     = {1'b0, x} + {1'b0, y};
          rs.carry = wide[W];
          rs.res   = (sat && rs.carry) ? '1 : wide[W-1:0];
        end
        OP_SUB: begin
          wide     = {1'b0, x} - {1'b0, y};
          rs.carry = (x < y);
          rs.res   = (sat && rs.carry) ? '0 : wide[W-1:0];
        end
        OP_AND: rs.res = x & y;
        OP_OR:  rs.res = x | y;
        OP_XOR: rs.res = x ^ y;
        OP_SHL: rs.res = x << y[SW-1:0];
        OP_SHR: rs.res = x >> y[SW-1:0];
        OP_MAX: rs.res = (x > y) ? x : y;
      endcase
    end
    return rs;
  endfunction

  logic                alive;
  logic                s1_full;
  logic [CH*W-1:0]     s1_a;
  logic [CH*W-1:0]     s1_b;
  logic [CH*OPW-1:0]   s1_op;
  logic                s1_sat;
  logic                s2_load;
  logic [CH*W-1:0]     res_c;
  logic [CH*2-1:0]     flg_c;
  logic [CH-1:0]       ill_c;

  for (genvar k = 0; k < CH; k++) begin : g_ch
    alu_res_t rs;
    assign rs              = alu_ch(s1_a[k*W +: W], s1_b[k*W +: W], s1_op[k*OPW +: OPW], s1_sat);
    assign res_c[k*W +: W] = rs.res;
    // An illegal opcode reports zero result but keeps the zero flag low.
    assign flg_c[2*k +: 2] = {rs.carry, ~rs.ill & (rs.res == '0)};
    assign ill_c[k]        = rs.ill;
  end

  // Stage 1 advances whenever stage 2 is empty or draining this cycle.
  assign s2_load  = s1_full & (~out_valid | out_ready);
  assign in_ready = alive & (~s1_full | s2_load);

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset along with the valid bits so r/flags read 0 out of reset.
      alive     <= 1'b0;
      s1_full   <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_op     <= '0;
      s1_sat    <= 1'b0;
      out_valid <= 1'b0;
      r         <= '0;
      flags     <= '0;
      err       <= 1'b0;
      txn_cnt   <= '0;
    end else begin
      alive <= 1'b1;
      if (in_ready) begin
        s1_full <= in_valid;
        if (in_valid) begin
          s1_a   <= a;
          s1_b   <= b;
          s1_op  <= op;
          s1_sat <= sat_en;
        end
      end
      if (s2_load) begin
        out_valid <= 1'b1;
        r         <= res_c;
        flags     <= flg_c;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // Setting wins over a simultaneous clear.
      err <= (s2_load & |ill_c) | (err & ~clr_err);
      if (out_valid && out_ready) txn_cnt <= txn_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_multi_alu_pipe.sv
// Self-checking bench for multi_alu_pipe: directed vector table, hand-written corner
// sequences, and randomized traffic scored against an arithmetic reference model.
module tb_multi_alu_pipe;
  localparam int W    = 8;
  localparam int CH   = 3;
  localparam int OPW  = 4;
  localparam int SB_N = 2048;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [23:0] a         = '0;
  logic [23:0] b         = '0;
  logic [11:0] op        = '0;
  logic        sat_en    = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] r;
  logic [5:0]  flags;
  logic        err;
  logic        clr_err   = 1'b0;
  logic [15:0] txn_cnt;

  always #5 clk = ~clk;

  multi_alu_pipe #(.W(W), .CH(CH), .OPW(OPW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .sat_en    (sat_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .flags     (flags),
    .err       (err),
    .clr_err   (clr_err),
    .txn_cnt   (txn_cnt)
  );

  typedef struct packed {
    logic [23:0] r;
    logic [5:0]  f;
  } res_t;

  typedef struct packed {
    logic [23:0] a;
    logic [23:0] b;
    logic [11:0] op;
    logic        sat;
    logic [23:0] er;
    logic [5:0]  ef;
    logic        ee;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: each channel computed with plain integer arithmetic.
  function automatic res_t model(input logic [23:0] av, input logic [23:0] bv,
                                 input logic [11:0] ov, input logic s);
    res_t m;
    int   x, y, o, v;
    logic c;
    m = '0;
    for (int k = 0; k < CH; k++) begin
      x = int'(av[k*W +: W]);
      y = int'(bv[k*W +: W]);
      o = int'(ov[k*OPW +: OPW]);
      v = 0;
      c = 1'b0;
      case (o)
        0: begin v = x + y; c = (v > 255); if (c) v = s ? 255 : v - 256; end
        1: begin c = (x < y); if (c) v = s ? 0 : x - y + 256; else v = x - y; end
        2: v = x & y;
        3: v = x | y;
        4: v = x ^ y;
        5: v = (x << (y % 8)) % 256;
        6: v = x >> (y % 8);
        7: v = (x > y) ? x : y;
        default: begin v = 0; c = 1'b0; end
      endcase
      m.r[k*W +: W]   = 8'(v);
      m.f[2*k +: 2]   = {c, (o < 8) && (v == 0)};
    end
    return m;
  endfunction

  // Monitor: records expected results on input handshakes and actual results on output handshakes.
  res_t        exp_arr [SB_N];
  res_t        act_arr [SB_N];
  int          exp_wr     = 0;
  int          act_wr     = 0;
  int          hs_total   = 0;
  int          stall_viol = 0;
  logic        sb_en      = 1'b0;
  logic        prev_stall = 1'b0;
  logic [23:0] prev_r     = '0;
  logic [5:0]  prev_f     = '0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_wr     <= 0;
      act_wr     <= 0;
      hs_total   <= 0;
      prev_stall <= 1'b0;
    end else begin
      if (sb_en && in_valid && in_ready) begin
        exp_arr[exp_wr % SB_N] <= model(a, b, op, sat_en);
        exp_wr <= exp_wr + 1;
      end
      if (out_valid && out_ready) begin
        hs_total <= hs_total + 1;
        if (sb_en) begin
          act_arr[act_wr % SB_N] <= '{r: r, f: flags};
          act_wr <= act_wr + 1;
        end
      end
      if (prev_stall && (!out_valid || r !== prev_r || flags !== prev_f))
        stall_viol <= stall_viol + 1;
      prev_stall <= out_valid && !out_ready;
      prev_r     <= r;
      prev_f     <= flags;
    end
  end

  int sb_rd = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_sb();
    while (sb_rd < act_wr) begin
      check($sformatf("sb_r[%0d]", sb_rd), 32'(act_arr[sb_rd % SB_N].r), 32'(exp_arr[sb_rd % SB_N].r));
      check($sformatf("sb_flags[%0d]", sb_rd), 32'(act_arr[sb_rd % SB_N].f), 32'(exp_arr[sb_rd % SB_N].f));
      sb_rd++;
    end
    check("sb_count", 32'(act_wr), 32'(exp_wr));
  endtask

  // Single bundle into an empty pipe with out_ready=1; result expected after the second edge.
  task automatic apply_vec(input vec_t v, input string tag);
    in_valid = 1'b1;
    a        = v.a;
    b        = v.b;
    op       = v.op;
    sat_en   = v.sat;
    tick();
    in_valid = 1'b0;
    check({tag, "_lat1"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_r"}, 32'(r), 32'(v.er));
    check({tag, "_flags"}, 32'(flags), 32'(v.ef));
    check({tag, "_err"}, 32'(err), 32'(v.ee));
  endtask

  initial begin
    vec_t        tbl [8];
    vec_t        v;
    int          idx;
    int          stall_in;
    logic        acc;
    logic [23:0] held_r;

    tbl[0] = '{a: 24'h0F0701, b: 24'h1F0103, op: 12'h410, sat: 1'b0, er: 24'h100604, ef: 6'b000000, ee: 1'b0};
    tbl[1] = '{a: 24'h0000FF, b: 24'h000002, op: 12'h000, sat: 1'b0, er: 24'h000001, ef: 6'b010110, ee: 1'b0};
    tbl[2] = '{a: 24'h0000FF, b: 24'h000002, op: 12'h000, sat: 1'b1, er: 24'h0000FF, ef: 6'b010110, ee: 1'b0};
    tbl[3] = '{a: 24'h800502, b: 24'h800205, op: 12'h111, sat: 1'b1, er: 24'h000300, ef: 6'b010011, ee: 1'b0};
    tbl[4] = '{a: 24'h3C8181, b: 24'h5A030B, op: 12'h765, sat: 1'b0, er: 24'h5A1008, ef: 6'b000000, ee: 1'b0};
    tbl[5] = '{a: 24'hF0F0AA, b: 24'h0F0FAA, op: 12'h324, sat: 1'b0, er: 24'hFF0000, ef: 6'b000101, ee: 1'b0};
    tbl[6] = '{a: 24'h00FF02, b: 24'h000105, op: 12'h001, sat: 1'b0, er: 24'h0000FD, ef: 6'b011110, ee: 1'b0};
    tbl[7] = '{a: 24'h015502, b: 24'h016603, op: 12'h090, sat: 1'b0, er: 24'h020005, ef: 6'b000000, ee: 1'b1};

    // Reset state.
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_r", 32'(r), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_txn_cnt", 32'(txn_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sb_en = 1'b1;
    tick();
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // Directed vectors.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));
    tick();

    // err stays set through a legal bundle, then clears.
    v    = tbl[0];
    v.ee = 1'b1;
    apply_vec(v, "err_sticky");
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("err_clr", 32'(err), 32'd0);

    // Clear asserted on the same edge an illegal opcode reaches stage 2.
    in_valid = 1'b1;
    a        = tbl[7].a;
    b        = tbl[7].b;
    op       = tbl[7].op;
    sat_en   = 1'b0;
    tick();
    in_valid = 1'b0;
    clr_err  = 1'b1;
    tick();
    clr_err  = 1'b0;
    check("err_set_wins", 32'(err), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("err_clr2", 32'(err), 32'd0);
    tick();
    drain_sb();

    // Backpressure: 4 back-to-back bundles, out_ready low for 5 cycles.
    idx    = 0;
    held_r = '0;
    for (int c = 0; c < 40 && idx < 4; c++) begin
      out_ready = (c >= 5);
      in_valid  = 1'b1;
      a         = {8'(8'h11 * (idx + 1)), 8'(idx), 8'hF0};
      b         = {8'(idx + 1), 8'h01, 8'(8'h20 * (idx + 1))};
      op        = 12'h100;
      sat_en    = 1'b0;
      #1;
      acc = in_ready;
      if (c == 2) begin
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_accepts", 32'(idx), 32'd2);
        held_r = r;
      end
      if (c == 4) begin
        check("bp_valid_held", 32'(out_valid), 32'd1);
        check("bp_r_held", 32'(r), 32'(held_r));
      end
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_all_accepted", 32'(idx), 32'd4);
    repeat (4) tick();
    drain_sb();

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a         = 24'($urandom);
      b         = 24'($urandom);
      sat_en    = 1'($urandom_range(0, 1));
      for (int k = 0; k < CH; k++) begin
        op[k*OPW +: OPW] = ($urandom_range(0, 7) == 0) ? 4'(8 + $urandom_range(0, 7))
                                                        : 4'($urandom_range(0, 7));
        if ($urandom_range(0, 7) == 0) a[k*W +: W] = 8'hFF;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    drain_sb();
    check("txn_cnt_random", 32'(txn_cnt), 32'(hs_total[15:0]));

    // Reset with two bundles in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a         = 24'h010203;
    b         = 24'h040506;
    op        = 12'h000;
    tick();
    tick();
    in_valid = 1'b0;
    check("mid_full_valid", 32'(out_valid), 32'd1);
    check("mid_full_ready", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_txn_cnt", 32'(txn_cnt), 32'd0);
    check("mid_rst_r", 32'(r), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    sb_en = 1'b0;
    sb_rd = 0;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("mid_rst_release_ready", 32'(in_ready), 32'd1);
    check("mid_rst_discarded", 32'(out_valid), 32'd0);

    // Sustained streaming through txn_cnt wrap.
    in_valid = 1'b1;
    stall_in = 0;
    for (int c = 0; c < 70000 && hs_total < 65537; c++) begin
      tick();
      if (!in_ready) stall_in++;
    end
    check("wrap_txn_cnt", 32'(txn_cnt), 32'd1);
    in_valid = 1'b0;
    check("wrap_handshakes", 32'(hs_total), 32'd65537);
    check("stream_no_stall", 32'(stall_in), 32'd0);

    check("hold_stable", 32'(stall_viol), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
